alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the single-cycle ALU circuits.
- Executes logic, arithmetic, compare, swap and multi-bit shift/rotate operations on a WIDTH-bit word, in full-word or half-word mode.
- Keeps a registered status register (zero, sign, carry) that ADC/SBC consume.
- Sits between the decode stage and the register-file writeback.
- Shifts and rotates are iterative, one bit per cycle.

Parameters:
- WIDTH, 20, datapath width; must be even and >= 4. HW = WIDTH/2.
- SHAMT_W, 5, width of the shift-amount input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  core can accept a request.
- op  in  4  opcode (see package).
- mode  in  1  1 = full-word (WIDTH bits), 0 = half-word (low HW bits).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- shamt  in  SHAMT_W  shift/rotate count.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  status flag Z.
- sign  out  1  status flag S.
- carry  out  1  status flag C.
- busy  out  1  shift/rotate iteration in progress.

Behaviour:
- Reset: clk and rst only. One clock; reset is synchronous and active-high. On rst, all of these go to 0 at the next edge: result, zero, sign, carry, out_valid, busy. State goes to IDLE and in_ready reads 1. A reset mid-operation aborts it and discards the result.
- FSM states and transitions:
  - IDLE to HOLD: accept a non-shift op, or a shift op with effective count 0.
  - IDLE to SHIFT: accept a shift op with effective count > 0.
  - SHIFT to HOLD: when the count reaches 0.
  - HOLD to IDLE: on out_valid && out_ready.
- Handshake:
  - in_ready = (state == IDLE). Accept when in_valid && in_ready; op, mode and operands are captured at acceptance.
  - out_valid = (state == HOLD). result and flags stay stable while out_valid && !out_ready.
- Latency: non-shift ops 1 cycle from accept to out_valid. Shift/rotate ops 1 + effective count cycles.
- busy = (state == SHIFT).
- Active width: N = WIDTH when mode = 1, N = HW when mode = 0. Operands are truncated to the low N bits. In half-word mode result[WIDTH-1:HW] = 0.
- Flags: Z = (result[N-1:0] == 0). S = result[N-1]. Flags update on the transition into HOLD; CMP updates flags only.
- Carry rules:
  - ADD, ADC, INC: carry = carry-out of bit N-1.
  - SUB, SBC, DEC, CMP: carry = borrow.
  - ADC adds the stored C; SBC subtracts the stored C.
  - Logic ops, SWP and rotates leave C unchanged.
  - SHR/SHL: C = last bit shifted out; C unchanged if the effective count is 0.
- Shifts: effective count = min(shamt, N), decremented once per SHIFT cycle. SHR/SHL are logical (zero fill). ROR/ROL rotate within N bits.
- SWP: result = a with its two N/2-bit halves exchanged.
- CMP: computes a - b for flags; result = a.
- All 16 opcodes are defined; there is no illegal-op path.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams, 4 bits: OP_NOT=0, OP_AND=1, OP_OR=2, OP_XOR=3, OP_ADD=4, OP_ADC=5, OP_SUB=6, OP_SBC=7, OP_INC=8, OP_DEC=9, OP_SHR=A, OP_SHL=B, OP_ROR=C, OP_ROL=D, OP_CMP=E, OP_SWP=F.
  - FSM state encodings: ST_IDLE, ST_SHIFT, ST_HOLD.
- Sub-module alu_seq_shifter: the iterative one-bit-per-cycle shift/rotate unit with its down-counter and carry capture.
- The core holds the FSM, the combinational single-cycle ops and the status register.

Test Plan (WIDTH=20):
- ADD, mode=1, a=0xFFFFF, b=0x00001 -> one cycle after accept: out_valid=1, result=0x00000, Z=1, C=1, S=0.
- Then ADC, mode=0, a=0xAB3FF, b=0x00000 (stored C=1) -> result=0x00000 (10-bit wrap of 0x3FF+1), Z=1, C=1. Then SUB, mode=1, a=5, b=7 -> result=0xFFFFE, S=1, C=1, Z=0.
- SHL, mode=1, a=0x80001, shamt=3 -> busy high 3 cycles, out_valid on cycle 4, result=0x00008, C=0.
- ROR, mode=0, a=0xABC01, shamt=1 -> result=0x00200 (upper half zeroed), S=1, C unchanged from the prior op.
- Backpressure: out_ready=0 for 5 cycles after a result -> result and flags stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> state returns to IDLE next cycle and in_ready=1.
- Reset mid-shift: SHR, shamt=15, rst=1 on the 5th SHIFT cycle -> next edge: busy=0, out_valid=0, result=0, flags=0, in_ready=1, and no result is ever delivered for that op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM encodings for the sequential ALU core.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOT = 4'h0;
    localparam logic [3:0] OP_AND = 4'h1;
    localparam logic [3:0] OP_OR  = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SBC = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_SHL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC;
    localparam logic [3:0] OP_ROL = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_SWP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // True for the four ops that go through the iterative shifter.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative shift/rotate unit: moves one bit per cycle within the active
// width and exposes the next-step value so the core can capture it on the
// final step.
module alu_seq_shifter #(
    parameter int WIDTH = 20,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             left,
    input  logic             rot,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic [CW-1:0]    cnt_in,
    output logic [WIDTH-1:0] step_data,
    output logic             step_cout,
    output logic             step_cen,
    output logic             step_sign,
    output logic             step_last
);

    localparam int HW = WIDTH / 2;
    localparam logic [WIDTH-1:0] MASK_H = {{(WIDTH-HW){1'b0}}, {HW{1'b1}}};
    localparam logic [WIDTH-1:0] TOP_F  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TOP_H  = {{(WIDTH-HW){1'b0}}, 1'b1, {(HW-1){1'b0}}};
    localparam logic [WIDTH-1:0] BIT0   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             left_q;
    logic             rot_q;
    logic             mode_q;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] top;
    logic             msb;

    // Remaining step count; cleared on reset so an aborted shift stops at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= cnt_in;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Working word and op attributes; data only, so no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= din;
            left_q <= left;
            rot_q  <= rot;
            mode_q <= mode;
        end else if (cnt_q != '0) begin
            data_q <= step_data;
        end
    end

    // One-bit move within the active width; rotates feed the bit back in.
    always_comb begin
        step_data = '0;
        step_cout = 1'b0;
        mask      = mode_q ? '1 : MASK_H;
        top       = mode_q ? TOP_F : TOP_H;
        msb       = mode_q ? data_q[WIDTH-1] : data_q[HW-1];
        if (left_q) begin
            step_cout = msb;
            step_data = ((data_q << 1) & mask) | ((rot_q && msb) ? BIT0 : '0);
        end else begin
            step_cout = data_q[0];
            step_data = (data_q >> 1) | ((rot_q && data_q[0]) ? top : '0);
        end
        step_cen  = !rot_q;
        step_sign = mode_q ? step_data[WIDTH-1] : step_data[HW-1];
        step_last = (cnt_q == CW'(1));
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: single-cycle logic/arithmetic ops, iterative
// shifts/rotates via alu_seq_shifter, and a Z/S/C status register.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               sign,
    output logic               carry,
    output logic               busy
);

    localparam int HW  = WIDTH / 2;
    localparam int QW  = HW / 2;
    localparam int NCW = $clog2(WIDTH + 1);
    localparam int CW  = (NCW > SHAMT_W) ? NCW : SHAMT_W;
    localparam logic [WIDTH-1:0] MASK_H = {{(WIDTH-HW){1'b0}}, {HW{1'b1}}};
    localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask, a_m, b_m;
    logic [WIDTH:0]   a_x, b_x, c_x, ar_x;
    logic [CW-1:0]    n_cnt, sh_ext, eff_cnt;
    logic             accept, go_shift;
    logic [WIDTH-1:0] alu_res, flag_val;
    logic             alu_c, alu_cen, arith;
    logic [WIDTH-1:0] sh_data;
    logic             sh_cout, sh_cen, sh_sign, sh_last;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_SHIFT);
    assign accept    = in_valid && in_ready;

    // Single-cycle ops on operands truncated to the active width; the extra
    // top bit of the arithmetic result carries out/borrows at bit N.
    always_comb begin
        mask    = mode ? '1 : MASK_H;
        a_m     = a & mask;
        b_m     = b & mask;
        a_x     = {1'b0, a_m};
        b_x     = {1'b0, b_m};
        c_x     = {{WIDTH{1'b0}}, carry};
        ar_x    = '0;
        alu_res = a_m;
        arith   = 1'b0;
        case (op)
            OP_NOT: alu_res = ~a & mask;
            OP_AND: alu_res = a_m & b_m;
            OP_OR:  alu_res = a_m | b_m;
            OP_XOR: alu_res = a_m ^ b_m;
            OP_ADD: begin ar_x = a_x + b_x;        arith = 1'b1; end
            OP_ADC: begin ar_x = a_x + b_x + c_x;  arith = 1'b1; end
            OP_SUB: begin ar_x = a_x - b_x;        arith = 1'b1; end
            OP_SBC: begin ar_x = a_x - b_x - c_x;  arith = 1'b1; end
            OP_INC: begin ar_x = a_x + ONE_X;      arith = 1'b1; end
            OP_DEC: begin ar_x = a_x - ONE_X;      arith = 1'b1; end
            OP_CMP: ar_x = a_x - b_x;
            OP_SWP: alu_res = mode ? {a_m[HW-1:0], a_m[WIDTH-1:HW]}
                                   : (((a_m >> QW) | (a_m << (HW - QW))) & mask);
            default: alu_res = a_m;
        endcase
        if (arith) begin
            alu_res = ar_x[WIDTH-1:0] & mask;
        end
        alu_cen  = arith || (op == OP_CMP);
        alu_c    = mode ? ar_x[WIDTH] : ar_x[HW];
        flag_val = (op == OP_CMP) ? (ar_x[WIDTH-1:0] & mask) : alu_res;
        n_cnt    = mode ? CW'(WIDTH) : CW'(HW);
        sh_ext   = CW'(shamt);
        eff_cnt  = (sh_ext > n_cnt) ? n_cnt : sh_ext;
        go_shift = is_shift_op(op) && (eff_cnt != '0);
    end

    alu_seq_shifter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && go_shift),
        .left      ((op == OP_SHL) || (op == OP_ROL)),
        .rot       ((op == OP_ROR) || (op == OP_ROL)),
        .mode      (mode),
        .din       (a_m),
        .cnt_in    (eff_cnt),
        .step_data (sh_data),
        .step_cout (sh_cout),
        .step_cen  (sh_cen),
        .step_sign (sh_sign),
        .step_last (sh_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: iterate for non-zero shifts, hold until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)    state_d = go_shift ? ST_SHIFT : ST_HOLD;
            ST_SHIFT: if (sh_last)   state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Result and status flags load only on entry to HOLD, so they stay put while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            sign   <= 1'b0;
            carry  <= 1'b0;
        end else if (accept && !go_shift) begin
            result <= alu_res;
            zero   <= (flag_val == '0);
            sign   <= mode ? flag_val[WIDTH-1] : flag_val[HW-1];
            if (alu_cen) carry <= alu_c;
        end else if (busy && sh_last) begin
            result <= sh_data;
            zero   <= (sh_data == '0);
            sign   <= sh_sign;
            if (sh_cen) carry <= sh_cout;
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised and directed bench for alu_seq_core against a plain-arithmetic model.
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  op;
    logic        mode;
    logic [19:0] a, b;
    logic [4:0]  shamt;
    logic        out_valid, out_ready;
    logic [19:0] result;
    logic        zero, sign, carry, busy;

    int errs   = 0;
    int checks = 0;
    logic c_mod = 1'b0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(20), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .sign      (sign),
        .carry     (carry),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: ALU behaviour computed with wide signed integers.
    function automatic void model(input logic [3:0] o, input logic md,
                                  input logic [19:0] aa, input logic [19:0] bb,
                                  input logic [4:0] sh, input logic cin,
                                  output logic [19:0] r, output logic z,
                                  output logic s, output logic c, output int lat);
        int n, k, h;
        longint m, av, bv, t, fv, ci;
        n   = md ? 20 : 10;
        h   = n / 2;
        m   = (longint'(1) << n) - 1;
        av  = longint'(aa) & m;
        bv  = longint'(bb) & m;
        ci  = cin ? 1 : 0;
        k   = (int'(sh) > n) ? n : int'(sh);
        c   = cin;
        lat = 1;
        t   = 0;
        case (o)
            4'h0: t = ~av;
            4'h1: t = av & bv;
            4'h2: t = av | bv;
            4'h3: t = av ^ bv;
            4'h4: begin t = av + bv;      c = t[n]; end
            4'h5: begin t = av + bv + ci; c = t[n]; end
            4'h6: begin t = av - bv;      c = (t < 0); end
            4'h7: begin t = av - bv - ci; c = (t < 0); end
            4'h8: begin t = av + 1;       c = t[n]; end
            4'h9: begin t = av - 1;       c = (t < 0); end
            4'hA: begin t = av >> k; lat = 1 + k; if (k > 0) c = av[k-1]; end
            4'hB: begin t = av << k; lat = 1 + k; if (k > 0) c = av[n-k]; end
            4'hC: begin t = (av >> k) | (av << (n - k)); lat = 1 + k; end
            4'hD: begin t = (av << k) | (av >> (n - k)); lat = 1 + k; end
            4'hE: begin t = av - bv; c = (t < 0); end
            default: t = ((av & ((longint'(1) << h) - 1)) << h) | (av >> h);
        endcase
        fv = t & m;
        r  = (o == 4'hE) ? 20'(av) : 20'(fv);
        z  = (fv == 0);
        s  = fv[n-1];
    endfunction

    task automatic run_op(input logic [3:0] o, input logic md, input logic [19:0] aa,
                          input logic [19:0] bb, input logic [4:0] sh, input int stall);
        logic [19:0] er;
        logic ez, es, ec;
        int el, cyc, nb;
        model(o, md, aa, bb, sh, c_mod, er, ez, es, ec, el);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        op = o; mode = md; a = aa; b = bb; shamt = sh;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; nb = 0;
        while (!out_valid && cyc <= 40) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, el);
        chk("busy_cycles", nb, el - 1);
        chk("result", {12'd0, result}, {12'd0, er});
        chk("flags_zsc", {29'd0, zero, sign, carry}, {29'd0, ez, es, ec});
        chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            op = 4'($urandom); a = 20'($urandom); shamt = 5'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_result", {12'd0, result}, {12'd0, er});
            chk("stall_flags", {29'd0, zero, sign, carry}, {29'd0, ez, es, ec});
            chk("stall_valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        c_mod = ec;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; mode = 1'b0; a = '0; b = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", {12'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, zero, sign, carry}, 32'd0);
        chk("rst_ctrl", {29'd0, out_valid, busy, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_ADD, 1'b1, 20'hFFFFF, 20'h00001, 5'd0, 0);
        run_op(OP_ADC, 1'b0, 20'hAB3FF, 20'h00000, 5'd0, 0);
        run_op(OP_SUB, 1'b1, 20'h00005, 20'h00007, 5'd0, 0);
        run_op(OP_SHL, 1'b1, 20'h80001, 20'h00000, 5'd3, 0);
        run_op(OP_ROR, 1'b0, 20'hABC01, 20'h00000, 5'd1, 0);
        run_op(OP_XOR, 1'b1, 20'h5A5A5, 20'h0F0F0, 5'd0, 5);
        run_op(OP_SHR, 1'b0, 20'h003FF, 20'h00000, 5'd31, 1);
        run_op(OP_ROL, 1'b1, 20'h80000, 20'h00000, 5'd0, 0);
        run_op(OP_SWP, 1'b0, 20'h0031F, 20'h00000, 5'd0, 0);
        run_op(OP_CMP, 1'b1, 20'h00003, 20'h00009, 5'd0, 0);

        // Abort a long shift with reset on its fifth SHIFT cycle.
        op = OP_SHR; mode = 1'b1; a = 20'hFFFFF; shamt = 5'd15; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy_first", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        chk("mid_busy_fifth", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_result", {12'd0, result}, 32'd0);
        chk("mid_rst_flags", {29'd0, zero, sign, carry}, 32'd0);
        chk("mid_rst_ctrl", {29'd0, out_valid, busy, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_no_result", {31'd0, seen}, 32'd0);
        c_mod = 1'b0;

        for (int i = 0; i < 120; i++) begin
            run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   20'($urandom), 20'($urandom), 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
